// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
//
// Two-requester round-robin arbiter in front of a UART transmitter. A granted
// byte is latched onto o_data_byte, a start strobe of PULSE_LEN cycles is
// issued, and the arbiter then waits for the transmitter's frame-complete
// pulse. It inserts GAP_CYCLES idle cycles before sampling requests again.
// Frames whose done pulse never arrives are abandoned after TIMEOUT cycles.
//
// Ports
//   i_clock       system clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_req_a/b     request from requester A/B (held until acked or dropped)
//   i_data_a/b    byte offered by requester A/B
//   o_ack_a/b     one-cycle pulse: that requester's byte was captured
//   o_tx_signal   start strobe to the UART transmitter
//   o_data_byte   byte presented to the transmitter, held until next grant
//   i_done_bit    transmitter frame-complete pulse
//   o_busy        high whenever the arbiter is not idle
//   o_grant_id    owner of current / most recent frame (0 = A, 1 = B)
//   o_timeout     one-cycle pulse when a frame is abandoned
//
// States
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_IDLE      | requests sampled; a grant moves to ST_START
//   ST_START     | o_tx_signal high for PULSE_LEN cycles
//   ST_WAIT_DONE | waiting for i_done_bit, bounded by TIMEOUT
//   ST_GAP       | GAP_CYCLES of enforced idle after a completed frame
// -----------------------------------------------------------------------------
module tx_arbiter #(
    parameter int NB_DATA    = 8,
    parameter int PULSE_LEN  = 2,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 2_000_000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_req_a,
    input  logic [NB_DATA-1:0] i_data_a,
    output logic               o_ack_a,
    input  logic               i_req_b,
    input  logic [NB_DATA-1:0] i_data_b,
    output logic               o_ack_b,
    output logic               o_tx_signal,
    output logic [NB_DATA-1:0] o_data_byte,
    input  logic               i_done_bit,
    output logic               o_busy,
    output logic               o_grant_id,
    output logic               o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    localparam int TMO_W    = 24;
    localparam int PLS_W    = 4;
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    // Terminal counts; the timeout counter fires when its incremented value
    // reaches TIMEOUT, i.e. TIMEOUT edges after the grant edge.
    localparam logic [TMO_W-1:0] TMO_TC = TMO_W'(TIMEOUT);
    localparam logic [PLS_W-1:0] PLS_TC = PLS_W'(PULSE_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(GAP_LAST);

    state_t               state_q,    state_d;
    logic [NB_DATA-1:0]   data_q,     data_d;
    logic                 grant_id_q, grant_id_d;
    logic                 ack_a_q,    ack_a_d;
    logic                 ack_b_q,    ack_b_d;
    logic                 timeout_q,  timeout_d;
    logic [TMO_W-1:0]     tmo_cnt_q,  tmo_cnt_d;
    logic [PLS_W-1:0]     pls_cnt_q,  pls_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q,  gap_cnt_d;

    logic                 req_any;
    logic                 win_b;
    logic [TMO_W-1:0]     tmo_inc;
    logic                 tmo_hit;

    // Round-robin: with both requesting, the one that did not own the last
    // frame wins. grant_id resets to B so A takes the first contention.
    assign req_any = i_req_a | i_req_b;
    assign win_b   = i_req_b & (~i_req_a | ~grant_id_q);
    assign tmo_inc = tmo_cnt_q + TMO_W'(1);
    assign tmo_hit = (tmo_inc == TMO_TC);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            grant_id_q <= 1'b1;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            timeout_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            pls_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            grant_id_q <= grant_id_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            timeout_q  <= timeout_d;
            tmo_cnt_q  <= tmo_cnt_d;
            pls_cnt_q  <= pls_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        grant_id_d = grant_id_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        timeout_d  = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;
        pls_cnt_d  = pls_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    data_d     = win_b ? i_data_b : i_data_a;
                    grant_id_d = win_b;
                    ack_a_d    = ~win_b;
                    ack_b_d    = win_b;
                    tmo_cnt_d  = '0;
                    pls_cnt_d  = '0;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                tmo_cnt_d = tmo_inc;
                // Done is not looked at here; only the timeout can cut the
                // strobe short (relevant only when TIMEOUT < PULSE_LEN).
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (pls_cnt_q == PLS_TC) begin
                    pls_cnt_d = '0;
                    state_d   = ST_WAIT_DONE;
                end else begin
                    pls_cnt_d = pls_cnt_q + PLS_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                tmo_cnt_d = tmo_inc;
                // Done is checked first so a done on the terminal-count edge
                // completes the frame normally without a timeout pulse.
                if (i_done_bit) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_TC) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_ack_a     = ack_a_q;
    assign o_ack_b     = ack_b_q;
    assign o_timeout   = timeout_q;
    assign o_data_byte = data_q;
    assign o_grant_id  = grant_id_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_tx_signal = (state_q == ST_START);

endmodule

// File: tb/tb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_arbiter
//
// Two arbiter instances share one stimulus stream:
//   inst 0: PULSE_LEN 2, GAP_CYCLES 4, TIMEOUT 50
//   inst 1: PULSE_LEN 3, GAP_CYCLES 0, TIMEOUT 50
// The reference model tracks each frame by timestamps (grant edge, edge at
// which the arbiter becomes idle again) and derives every output from the
// distance in edges to those events.
// -----------------------------------------------------------------------------
module tb_tx_arbiter;

    localparam int TMO   = 50;
    localparam int NEVER = 32'h3fff_ffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_a, req_b, done;
    logic [7:0] data_a, data_b;
    logic [1:0] ack_a, ack_b, tx, busy, gid, tmo;
    logic [7:0] dout [2];

    tx_arbiter #(.NB_DATA(8), .PULSE_LEN(2), .GAP_CYCLES(4), .TIMEOUT(TMO)) u_dut0 (
        .i_clock(clk), .i_reset(rst_n),
        .i_req_a(req_a), .i_data_a(data_a), .o_ack_a(ack_a[0]),
        .i_req_b(req_b), .i_data_b(data_b), .o_ack_b(ack_b[0]),
        .o_tx_signal(tx[0]), .o_data_byte(dout[0]), .i_done_bit(done),
        .o_busy(busy[0]), .o_grant_id(gid[0]), .o_timeout(tmo[0])
    );

    tx_arbiter #(.NB_DATA(8), .PULSE_LEN(3), .GAP_CYCLES(0), .TIMEOUT(TMO)) u_dut1 (
        .i_clock(clk), .i_reset(rst_n),
        .i_req_a(req_a), .i_data_a(data_a), .o_ack_a(ack_a[1]),
        .i_req_b(req_b), .i_data_b(data_b), .o_ack_b(ack_b[1]),
        .o_tx_signal(tx[1]), .o_data_byte(dout[1]), .i_done_bit(done),
        .o_busy(busy[1]), .o_grant_id(gid[1]), .o_timeout(tmo[1])
    );

    function automatic int pulse_len(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int gap_len(int i);
        return (i == 0) ? 4 : 0;
    endfunction

    // model state
    int         n;
    bit         m_open      [2];
    int         m_grant_t   [2];
    int         m_idle_from [2];
    bit         m_gid       [2];
    logic [7:0] m_data      [2];
    bit         m_ack_a     [2];
    bit         m_ack_b     [2];
    bit         m_tmo       [2];

    int n_checks = 0;
    int n_errors = 0;
    int cnt_ack_a0, cnt_tx0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_open[i]      = 1'b0;
            m_grant_t[i]   = 0;
            m_idle_from[i] = n;
            m_gid[i]       = 1'b1;
            m_data[i]      = 8'h00;
            m_ack_a[i]     = 1'b0;
            m_ack_b[i]     = 1'b0;
            m_tmo[i]       = 1'b0;
        end
    endtask

    // Called right after a rising edge with the inputs that edge sampled.
    task automatic model_edge();
        int  d;
        bit  wb;
        n++;
        for (int i = 0; i < 2; i++) begin
            m_ack_a[i] = 1'b0;
            m_ack_b[i] = 1'b0;
            m_tmo[i]   = 1'b0;
            if (m_open[i]) begin
                d = n - m_grant_t[i];
                if (done && d >= pulse_len(i) + 1) begin
                    m_open[i]      = 1'b0;
                    m_idle_from[i] = n + gap_len(i);
                end else if (d == TMO) begin
                    m_open[i]      = 1'b0;
                    m_idle_from[i] = n;
                    m_tmo[i]       = 1'b1;
                end
            end else if (n > m_idle_from[i] && (req_a || req_b)) begin
                wb             = (req_a && req_b) ? !m_gid[i] : req_b;
                m_gid[i]       = wb;
                m_data[i]      = wb ? data_b : data_a;
                m_ack_a[i]     = !wb;
                m_ack_b[i]     = wb;
                m_grant_t[i]   = n;
                m_open[i]      = 1'b1;
                m_idle_from[i] = NEVER;
            end
        end
    endtask

    task automatic compare();
        bit e_busy, e_tx;
        for (int i = 0; i < 2; i++) begin
            e_busy = (n < m_idle_from[i]);
            e_tx   = m_open[i] && ((n - m_grant_t[i]) < pulse_len(i));
            check($sformatf("ack_a%0d", i), ack_a[i], m_ack_a[i]);
            check($sformatf("ack_b%0d", i), ack_b[i], m_ack_b[i]);
            check($sformatf("tx%0d", i),    tx[i],    e_tx);
            check($sformatf("busy%0d", i),  busy[i],  e_busy);
            check($sformatf("gid%0d", i),   gid[i],   m_gid[i]);
            check($sformatf("data%0d", i),  dout[i],  m_data[i]);
            check($sformatf("tmo%0d", i),   tmo[i],   m_tmo[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        if (ack_a[0]) cnt_ack_a0++;
        if (tx[0])    cnt_tx0++;
    endtask

    // Entered at a falling edge; reset is asserted mid-phase with no clock
    // edge before the outputs are inspected.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_ack_a%0d", i), ack_a[i], 0);
            check($sformatf("rst_ack_b%0d", i), ack_b[i], 0);
            check($sformatf("rst_tx%0d", i),    tx[i],    0);
            check($sformatf("rst_busy%0d", i),  busy[i],  0);
            check($sformatf("rst_tmo%0d", i),   tmo[i],   0);
            check($sformatf("rst_gid%0d", i),   gid[i],   1);
            check($sformatf("rst_data%0d", i),  dout[i],  0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int         nfr, k_tmo, last0, last1, nsp1, dmod;
    int         gseq [3];
    logic [7:0] dseq [3];
    logic [7:0] exp_d [3];

    initial begin
        n      = 0;
        rst_n  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        done   = 1'b0;
        data_a = 8'h00;
        data_b = 8'h00;
        @(negedge clk);

        // A alone, 8'hAA, done 10 cycles after grant
        do_reset();
        cnt_ack_a0 = 0;
        cnt_tx0    = 0;
        req_a  = 1'b1;
        data_a = 8'hAA;
        step();
        check("s1_data", dout[0], 8'hAA);
        req_a = 1'b0;
        repeat (9) step();
        done = 1'b1;
        step();
        done = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("s1_busy_tail", busy[0], (k < 4));
        end
        check("s1_ack_cnt", cnt_ack_a0, 1);
        check("s1_tx_cnt", cnt_tx0, 2);

        // A and B contending from reset, done held high
        do_reset();
        req_a  = 1'b1; data_a = 8'h55;
        req_b  = 1'b1; data_b = 8'h0F;
        done   = 1'b1;
        nfr    = 0;
        for (int j = 0; j < 3; j++) begin
            gseq[j] = 2;
            dseq[j] = 8'hxx;
        end
        exp_d[0] = 8'h55; exp_d[1] = 8'h0F; exp_d[2] = 8'h55;
        for (int k = 0; k < 40 && nfr < 3; k++) begin
            step();
            if (ack_a[0] || ack_b[0]) begin
                gseq[nfr] = gid[0];
                dseq[nfr] = dout[0];
                nfr++;
            end
        end
        check("s2_frames", nfr, 3);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("s2_gid%0d", j), gseq[j], j % 2);
            check($sformatf("s2_byte%0d", j), dseq[j], exp_d[j]);
        end
        req_a = 1'b0; req_b = 1'b0; done = 1'b0;
        repeat (12) step();

        // no done: timeout after 50 edges, then immediate re-grant
        do_reset();
        req_a  = 1'b1; data_a = 8'h3C;
        step();
        req_a  = 1'b0;
        k_tmo  = -1;
        for (int k = 1; k <= 60 && k_tmo < 0; k++) begin
            step();
            if (tmo[0]) k_tmo = k;
        end
        check("s3_tmo_delay", k_tmo, 50);
        check("s3_idle_after_tmo", busy[0], 0);
        req_a  = 1'b1; data_a = 8'h81;
        step();
        check("s3_regrant", ack_a[0], 1);
        req_a  = 1'b0;
        repeat (4) step();
        done = 1'b1;
        step();
        done = 1'b0;
        repeat (6) step();

        // done during START and GAP is ignored
        do_reset();
        req_a  = 1'b1; data_a = 8'h5A;
        step();
        req_a  = 1'b0;
        done   = 1'b1;
        step();
        done   = 1'b0;
        check("s4_start_hold", tx[0], 1);
        repeat (3) step();
        check("s4_wait_busy", busy[0], 1);
        check("s4_wait_tx", tx[0], 0);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        check("s4_gap_busy", busy[0], 1);
        step();
        check("s4_gap_end", busy[0], 0);
        repeat (3) step();

        // reset during WAIT_DONE, then a pending B is granted
        do_reset();
        req_a  = 1'b1; data_a = 8'hC3;
        step();
        req_a  = 1'b0;
        repeat (4) step();
        check("s5_in_wait", busy[0] & ~tx[0], 1);
        req_b  = 1'b1; data_b = 8'h96;
        do_reset();
        step();
        check("s5_ack_b", ack_b[0], 1);
        check("s5_gid", gid[0], 1);
        check("s5_byte", dout[0], 8'h96);
        req_b = 1'b0;
        repeat (4) step();
        done = 1'b1;
        step();
        done = 1'b0;
        repeat (6) step();

        // A held, done held: back-to-back grant spacing
        do_reset();
        req_a  = 1'b1; data_a = 8'h11;
        done   = 1'b1;
        last0  = -1;
        last1  = -1;
        nsp1   = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (ack_a[0]) begin
                if (last0 >= 0) check("s6_spacing0", k - last0, 8);
                last0 = k;
            end
            if (ack_a[1]) begin
                if (last1 >= 0) begin
                    check("s6_spacing1", k - last1, 5);
                    nsp1++;
                end
                last1 = k;
            end
        end
        check("s6_frames1", (nsp1 >= 4), 1);
        req_a = 1'b0;
        done  = 1'b0;
        repeat (12) step();

        // randomized traffic with varying done density and occasional resets
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            case (blk % 4)
                0:       dmod = 2;
                1:       dmod = 6;
                2:       dmod = 0;
                default: dmod = 25;
            endcase
            for (int k = 0; k < 250; k++) begin
                if (req_a) begin
                    if ($urandom_range(0, 7) == 0) req_a = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_a  = 1'b1;
                    data_a = 8'($urandom);
                end
                if (req_b) begin
                    if ($urandom_range(0, 7) == 0) req_b = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_b  = 1'b1;
                    data_b = 8'($urandom);
                end
                done = (dmod != 0) && ($urandom_range(0, dmod - 1) == 0);
                if ($urandom_range(0, 399) == 0) do_reset();
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NB_DATA, default 8, data byte width.
REQ-002 Parameter PULSE_LEN, default 2, number of cycles o_tx_signal stays high per frame (range 1..15).
REQ-003 Parameter GAP_CYCLES, default 4, idle cycles inserted after each frame (0 allowed).
REQ-004 Parameter TIMEOUT, default 2_000_000, maximum cycles to wait for i_done_bit after start (fits 24 bits).
REQ-005 i_clock  in  1  system clock; all state changes on rising edge.
REQ-006 i_reset  in  1  reset; asynchronous and active-low.
REQ-007 i_req_a  in  1  requester A wants to send i_data_a.
REQ-008 i_data_a  in  NB_DATA  requester A byte; held stable while i_req_a is high.
REQ-009 o_ack_a  out  1  one-cycle pulse, A's byte captured.
REQ-010 i_req_b / i_data_b / o_ack_b  as REQ-007..009 for requester B.
REQ-011 o_tx_signal  out  1  start strobe to UART_TX.
REQ-012 o_data_byte  out  NB_DATA  byte driven to UART_TX, held until the next grant.
REQ-013 i_done_bit  in  1  UART_TX frame-complete pulse.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_grant_id  out  1  0 = A, 1 = B; owner of the current or most recent frame.
REQ-016 o_timeout  out  1  one-cycle pulse when a frame is abandoned.

Function
REQ-017 States: IDLE, START, WAIT_DONE, GAP; the encoding is free.
REQ-018 Requests are sampled only in IDLE.
REQ-019 Arbitration at the sampling edge:
  - Single request: it wins.
  - Both requesting: the requester not in o_grant_id wins (round-robin).
REQ-020 At the grant edge:
  - o_data_byte loads the winner's data.
  - o_grant_id updates.
  - State goes to START.
  - The winner's ack is high for exactly the next cycle.
REQ-021 In START, o_tx_signal is high for PULSE_LEN consecutive cycles, starting the cycle after the grant edge; state then goes to WAIT_DONE.
REQ-022 o_tx_signal is low in every other state.
REQ-023 In WAIT_DONE, i_done_bit high at an edge moves the state to GAP, or to IDLE if GAP_CYCLES == 0.
REQ-024 i_done_bit is ignored in IDLE, START and GAP.
REQ-025 GAP lasts exactly GAP_CYCLES cycles, then the state goes to IDLE; requests are not sampled during GAP.
REQ-026 Timeout counter behaviour:
  - Clears at the grant edge.
  - Increments every cycle in START and WAIT_DONE.
  - On reaching TIMEOUT without done: o_timeout pulses one cycle, state goes to IDLE, no gap.
REQ-027 i_done_bit and the timeout terminal count on the same edge: done wins, o_timeout stays low.
REQ-028 A request still high in IDLE after its ack is treated as a new request.
REQ-029 Minimum grant-to-grant spacing is PULSE_LEN + 1 + GAP_CYCLES + 1 cycles.
REQ-030 A request dropped before grant is lost without ack; there is no buffering beyond o_data_byte.

Reset
REQ-031 On i_reset low, immediately and independent of i_clock:
  - state = IDLE
  - o_tx_signal, o_ack_a, o_ack_b, o_busy, o_timeout = 0
  - o_data_byte = 0
  - o_grant_id = 1, so A wins the first contention
  - timeout and pulse counters = 0
REQ-032 Reset asserted mid-frame abandons the frame with no ack or timeout pulse; the first sampling edge is the first rising edge after i_reset returns high.

Verification
REQ-033 Scenario: A alone, data 8'hAA, UART_TX done after 10 cycles.
  - o_ack_a pulses once.
  - o_tx_signal is high 2 cycles.
  - o_data_byte = 8'hAA.
  - o_busy falls 4 cycles after done.
REQ-034 Scenario: A = 8'h55 and B = 8'h0F both requesting from reset, held high across two frames.
  - Frame order A, B, A, ...
  - o_grant_id sequence 0, 1, 0.
REQ-035 Scenario: i_done_bit never arrives, with TIMEOUT overridden to 50.
  - o_timeout pulses 50 cycles after grant.
  - Back in IDLE; a new A request is granted on the next edge.
REQ-036 Scenario: i_done_bit pulsed during START and during GAP.
  - No state change.
  - Only a done in WAIT_DONE ends the frame.
REQ-037 Scenario: i_reset low during WAIT_DONE.
  - All outputs go to reset values without a clock edge.
  - After release, a pending B request is granted.
REQ-038 Scenario: GAP_CYCLES = 0 with A held high.
  - Back-to-back frames with grant spacing PULSE_LEN + 2 cycles after done.
